// File: rtl/dsp_alu_arbiter_pkg.sv
// rtl/dsp_alu_arbiter_pkg.sv - opcode map, ALU mode constants and decode function
//
// Package dsp_alu_arb_pkg
//   OP_*          : abstract opcodes accepted from the requesters
//   ALUMODE_*     : DSP48E1 ALUMODE settings used by the op map
//   OPMODE_*      : DSP48E1 OPMODE settings (X/Z only, or X/Y/Z with Y = C all-ones)
//   op_dec_t      : decoded op {alumode, opmode, y_allones, err}
//   burst_state_t : arbiter burst FSM states
//   decode_op()   : opcode -> op_dec_t
package dsp_alu_arb_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;

  localparam logic [3:0] ALUMODE_ADD  = 4'b0000;
  localparam logic [3:0] ALUMODE_SUB  = 4'b0011;
  localparam logic [3:0] ALUMODE_XOR  = 4'b0100;
  localparam logic [3:0] ALUMODE_AND  = 4'b1100;
  // Forces P = 0 / COUT = 0 for opcodes we refuse to execute.
  localparam logic [3:0] ALUMODE_ZERO = 4'b1000;

  localparam logic [6:0] OPMODE_XZ  = 7'b0110011;
  localparam logic [6:0] OPMODE_XYZ = 7'b0111011;

  typedef struct packed {
    logic [3:0] alumode;
    logic [6:0] opmode;
    logic       y_allones;
    logic       err;
  } op_dec_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

  // XNOR and OR reuse the XOR/AND ALU modes with Y forced to all-ones,
  // which inverts / widens the logic function inside the DSP slice.
  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d.alumode   = ALUMODE_ZERO;
    d.opmode    = OPMODE_XZ;
    d.y_allones = 1'b0;
    d.err       = 1'b1;
    case (op)
      OP_ADD:  begin d.alumode = ALUMODE_ADD; d.err = 1'b0; end
      OP_SUB:  begin d.alumode = ALUMODE_SUB; d.err = 1'b0; end
      OP_XOR:  begin d.alumode = ALUMODE_XOR; d.err = 1'b0; end
      OP_XNOR: begin
        d.alumode = ALUMODE_XOR; d.opmode = OPMODE_XYZ; d.y_allones = 1'b1; d.err = 1'b0;
      end
      OP_AND:  begin d.alumode = ALUMODE_AND; d.err = 1'b0; end
      OP_OR:   begin
        d.alumode = ALUMODE_AND; d.opmode = OPMODE_XYZ; d.y_allones = 1'b1; d.err = 1'b0;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dsp_alu_arbiter_if.sv
// rtl/dsp_alu_arbiter_if.sv - request, ALU-side and response bundle for the arbiter
//
// Interface dsp_alu_arbiter_if #(N)
//   REQ0_* / REQ1_* : per-client request (VALID, READY, OP, X, Z, CIN, LOCK)
//   X_OUT..OPMODE_R : registered ALU operands and modes
//   P_IN, COUT      : ALU result returned to the arbiter
//   RSP_*           : tagged response (VALID, ID, P, COUT, ERR)
// Modports: slave = arbiter side, master = clients + ALU side.
interface dsp_alu_arbiter_if #(parameter int N = 48);
  logic         REQ0_VALID, REQ0_READY, REQ0_CIN, REQ0_LOCK;
  logic [2:0]   REQ0_OP;
  logic [N-1:0] REQ0_X, REQ0_Z;
  logic         REQ1_VALID, REQ1_READY, REQ1_CIN, REQ1_LOCK;
  logic [2:0]   REQ1_OP;
  logic [N-1:0] REQ1_X, REQ1_Z;
  logic [N-1:0] X_OUT, Y_OUT, Z_OUT;
  logic         CIN;
  logic [3:0]   ALUMODE_R;
  logic [6:0]   OPMODE_R;
  logic [N-1:0] P_IN;
  logic         COUT;
  logic         RSP_VALID, RSP_ID, RSP_COUT, RSP_ERR;
  logic [N-1:0] RSP_P;

  modport slave (
    input  REQ0_VALID, REQ0_OP, REQ0_X, REQ0_Z, REQ0_CIN, REQ0_LOCK,
    input  REQ1_VALID, REQ1_OP, REQ1_X, REQ1_Z, REQ1_CIN, REQ1_LOCK,
    output REQ0_READY, REQ1_READY,
    output X_OUT, Y_OUT, Z_OUT, CIN, ALUMODE_R, OPMODE_R,
    input  P_IN, COUT,
    output RSP_VALID, RSP_ID, RSP_P, RSP_COUT, RSP_ERR
  );

  modport master (
    output REQ0_VALID, REQ0_OP, REQ0_X, REQ0_Z, REQ0_CIN, REQ0_LOCK,
    output REQ1_VALID, REQ1_OP, REQ1_X, REQ1_Z, REQ1_CIN, REQ1_LOCK,
    input  REQ0_READY, REQ1_READY,
    input  X_OUT, Y_OUT, Z_OUT, CIN, ALUMODE_R, OPMODE_R,
    output P_IN, COUT,
    input  RSP_VALID, RSP_ID, RSP_P, RSP_COUT, RSP_ERR
  );
endinterface

// File: rtl/dsp_alu_arbiter_op_decode.sv
// rtl/dsp_alu_arbiter_op_decode.sv - combinational opcode decode for the granted request
//
// Module dsp_alu_op_decode
//   op  in  3        : opcode of the granted request
//   dec out op_dec_t : {alumode, opmode, y_allones, err}
module dsp_alu_op_decode
  import dsp_alu_arb_pkg::*;
(
  input  logic [2:0] op,
  output op_dec_t    dec
);

  always_comb begin
    dec = decode_op(op);
  end

endmodule

// File: rtl/dsp_alu_arbiter.sv
// rtl/dsp_alu_arbiter.sv - two-client round-robin arbiter and op sequencer for a DSP48E1 ALU
//
// Module dsp_alu_arbiter #(N, PLAT, MAX_BURST)
//   CLK  in : clock, rising edge
//   RST  in : synchronous active-high reset
//   bus     : dsp_alu_arbiter_if.slave (requests, ALU operands/modes, ALU result, responses)
module dsp_alu_arbiter
  import dsp_alu_arb_pkg::*;
#(
  parameter int N         = 48,
  parameter int PLAT      = 1,
  parameter int MAX_BURST = 4
) (
  input logic              CLK,
  input logic              RST,
  dsp_alu_arbiter_if.slave bus
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  burst_state_t state, state_nx;
  logic         ptr, ptr_nx;
  logic         owner, owner_nx;
  logic [3:0]   bcnt, bcnt_nx;

  logic grant, gid, burst_win, fire;
  logic own_valid, own_lock, oth_valid, g_lock;

  logic [2:0]   op_sel;
  logic [N-1:0] x_sel, z_sel;
  logic         cin_sel;
  op_dec_t      dec;

  // Tag pipeline: stage k holds the op whose operands entered the ALU k+1 cycles ago.
  logic tag_v   [PLAT];
  logic tag_id  [PLAT];
  logic tag_err [PLAT];

  always_comb begin
    grant     = 1'b0;
    gid       = ptr;
    burst_win = 1'b0;
    state_nx  = state;
    ptr_nx    = ptr;
    owner_nx  = owner;
    bcnt_nx   = bcnt;

    own_valid = owner ? bus.REQ1_VALID : bus.REQ0_VALID;
    own_lock  = owner ? bus.REQ1_LOCK  : bus.REQ0_LOCK;
    oth_valid = owner ? bus.REQ0_VALID : bus.REQ1_VALID;

    // A locked owner keeps the slice until it has used MAX_BURST grants
    // while the other side is waiting; otherwise plain round-robin applies.
    if (state == ST_BURST && own_valid && own_lock && (bcnt < MAXB || !oth_valid)) begin
      burst_win = 1'b1;
      grant     = 1'b1;
      gid       = owner;
    end else if (bus.REQ0_VALID && bus.REQ1_VALID) begin
      grant = 1'b1;
      gid   = ptr;
    end else if (bus.REQ0_VALID) begin
      grant = 1'b1;
      gid   = 1'b0;
    end else if (bus.REQ1_VALID) begin
      grant = 1'b1;
      gid   = 1'b1;
    end

    g_lock = gid ? bus.REQ1_LOCK : bus.REQ0_LOCK;

    if (grant) begin
      ptr_nx = ~gid;
      if (burst_win) begin
        bcnt_nx = (bcnt < MAXB) ? bcnt + 4'd1 : bcnt;
      end else if (g_lock) begin
        // Any non-continuation grant carrying LOCK opens a fresh burst.
        state_nx = ST_BURST;
        owner_nx = gid;
        bcnt_nx  = 4'd1;
      end else begin
        state_nx = ST_IDLE;
        bcnt_nx  = 4'd0;
      end
    end else begin
      // No grant means the owner has dropped VALID.
      state_nx = ST_IDLE;
      bcnt_nx  = 4'd0;
    end
  end

  assign fire           = grant & ~RST;
  assign bus.REQ0_READY = fire & ~gid;
  assign bus.REQ1_READY = fire & gid;

  assign op_sel  = gid ? bus.REQ1_OP  : bus.REQ0_OP;
  assign x_sel   = gid ? bus.REQ1_X   : bus.REQ0_X;
  assign z_sel   = gid ? bus.REQ1_Z   : bus.REQ0_Z;
  assign cin_sel = gid ? bus.REQ1_CIN : bus.REQ0_CIN;

  dsp_alu_op_decode u_decode (
    .op  (op_sel),
    .dec (dec)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      bcnt          <= 4'd0;
      bus.X_OUT     <= '0;
      bus.Y_OUT     <= '0;
      bus.Z_OUT     <= '0;
      bus.CIN       <= 1'b0;
      bus.ALUMODE_R <= 4'd0;
      bus.OPMODE_R  <= 7'd0;
      for (int i = 0; i < PLAT; i++) begin
        tag_v[i]   <= 1'b0;
        tag_id[i]  <= 1'b0;
        tag_err[i] <= 1'b0;
      end
      bus.RSP_VALID <= 1'b0;
      bus.RSP_ID    <= 1'b0;
      bus.RSP_P     <= '0;
      bus.RSP_COUT  <= 1'b0;
      bus.RSP_ERR   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      bcnt  <= bcnt_nx;

      // Idle cycles leave the ALU inputs untouched.
      if (grant) begin
        bus.X_OUT     <= x_sel;
        bus.Y_OUT     <= {N{dec.y_allones}};
        bus.Z_OUT     <= z_sel;
        bus.CIN       <= cin_sel;
        bus.ALUMODE_R <= dec.alumode;
        bus.OPMODE_R  <= dec.opmode;
      end

      tag_v[0]   <= grant;
      tag_id[0]  <= gid;
      tag_err[0] <= dec.err;
      for (int i = 1; i < PLAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_id[i]  <= tag_id[i-1];
        tag_err[i] <= tag_err[i-1];
      end

      // Response fields are zero whenever no op completes.
      bus.RSP_VALID <= tag_v[PLAT-1];
      bus.RSP_ID    <= tag_v[PLAT-1] & tag_id[PLAT-1];
      bus.RSP_ERR   <= tag_v[PLAT-1] & tag_err[PLAT-1];
      bus.RSP_P     <= tag_v[PLAT-1] ? bus.P_IN : '0;
      bus.RSP_COUT  <= tag_v[PLAT-1] & bus.COUT;
    end
  end

endmodule
